// File: rtl/pio_fifo.sv
// pio_fifo -- first-word-fall-through FIFO between a PIO state machine and
// its host/DMA side. One instance per direction (TX or RX) per state machine.
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   data_in       word written on an accepted push
//   push_en       write request
//   pop_en        read/advance request
//   data_out      current head word (0 while empty), combinational
//   status        {full, empty}, decoded from fifo_count
//   fifo_count    occupancy, 0..DEPTH
//   overflow      sticky, set by a dropped push      (PIO_FIFO_ERR_FLAGS_EN only)
//   underflow     sticky, set by a pop while empty   (PIO_FIFO_ERR_FLAGS_EN only)
//
// memory, head and tail are kept as plainly named internals so that the state
// machine and the bench can observe them hierarchically.
//
// Build option: define PIO_FIFO_ERR_FLAGS_EN to add the overflow/underflow
// outputs. Without it those conditions are silently ignored.

package pio_fifo_pkg;
  // Status word shared with the rest of the PIO block.
  typedef struct packed {
    logic full;
    logic empty;
  } fifo_status;
endpackage

module pio_fifo
  import pio_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     push_en,
  input  logic                     pop_en,
  output logic [WIDTH-1:0]         data_out,
  output fifo_status               status,
`ifdef PIO_FIFO_ERR_FLAGS_EN
  output logic                     overflow,
  output logic                     underflow,
`endif
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] memory [0:DEPTH-1];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  logic full, empty;
  logic push_ok, pop_ok;

  assign empty = (fifo_count == CW'(0));
  assign full  = (fifo_count == CW'(DEPTH));

  assign status.full  = full;
  assign status.empty = empty;

  assign data_out = empty ? '0 : memory[head];

  // When full, a simultaneous pop frees the slot at head == tail, so the push
  // may land there in the same edge. A full FIFO is never empty, so that pop
  // is always accepted too.
  assign push_ok = push_en && (!full || pop_en);
  assign pop_ok  = pop_en && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
      for (int i = 0; i < DEPTH; i++) memory[i] <= '0;
    end else begin
      if (push_ok) begin
        memory[tail] <= data_in;
        tail         <= tail + PW'(1);
      end
      if (pop_ok) head <= head + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef PIO_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_en && !push_ok) overflow  <= 1'b1;
      if (pop_en && empty)     underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pio_fifo.sv
// Directed self-checking bench for pio_fifo (WIDTH=32, DEPTH=4).
module tb_pio_fifo;
  import pio_fifo_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic        push_en;
  logic        pop_en;
  logic [31:0] data_out;
  fifo_status  status;
  logic [2:0]  fifo_count;
`ifdef PIO_FIFO_ERR_FLAGS_EN
  logic        overflow;
  logic        underflow;
`endif

  int total = 0;
  int bad   = 0;

  pio_fifo #(.WIDTH(32), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .push_en   (push_en),
    .pop_en    (pop_en),
    .data_out  (data_out),
    .status    (status),
`ifdef PIO_FIFO_ERR_FLAGS_EN
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    chk({tag, "_m0"}, dut.memory[0], e0);
    chk({tag, "_m1"}, dut.memory[1], e1);
    chk({tag, "_m2"}, dut.memory[2], e2);
    chk({tag, "_m3"}, dut.memory[3], e3);
  endtask

  // Apply one cycle of push/pop, then sample 1 time unit after the edge.
  task automatic cyc(input logic pu, input logic po, input logic [31:0] d);
    push_en = pu;
    pop_en  = po;
    data_in = d;
    @(posedge clk);
    #1;
    push_en = 1'b0;
    pop_en  = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_seq [4];

    rst = 1'b0; push_en = 1'b0; pop_en = 1'b0; data_in = '0;

    // Reset state, before any clock edge.
    #3;
    chk("rst_empty", 32'(status.empty), 32'd1);
    chk("rst_full",  32'(status.full),  32'd0);
    chk("rst_count", 32'(fifo_count),   32'd0);
    chk("rst_head",  32'(dut.head),     32'd0);
    chk("rst_tail",  32'(dut.tail),     32'd0);
    chk("rst_dout",  data_out,          32'd0);
    chk_mem("rst", 0, 0, 0, 0);
`ifdef PIO_FIFO_ERR_FLAGS_EN
    chk("rst_ovf", 32'(overflow),  32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;

    // Fill.
    cyc(1, 0, 32'hA);
    chk("fill1_dout",  data_out,        32'hA);
    chk("fill1_count", 32'(fifo_count), 32'd1);
    cyc(1, 0, 32'hB);
    cyc(1, 0, 32'hC);
    cyc(1, 0, 32'hD);
    chk("fill_count", 32'(fifo_count),   32'd4);
    chk("fill_full",  32'(status.full),  32'd1);
    chk("fill_empty", 32'(status.empty), 32'd0);
    chk("fill_tail",  32'(dut.tail),     32'd0);
    chk("fill_dout",  data_out,          32'hA);
    chk_mem("fill", 32'hA, 32'hB, 32'hC, 32'hD);

    // Push while full, no pop: dropped.
    cyc(1, 0, 32'hE);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_tail",  32'(dut.tail),   32'd0);
    chk("ovf_head",  32'(dut.head),   32'd0);
    chk("ovf_dout",  data_out,        32'hA);
    chk_mem("ovf", 32'hA, 32'hB, 32'hC, 32'hD);
`ifdef PIO_FIFO_ERR_FLAGS_EN
    chk("ovf_flag", 32'(overflow),  32'd1);
    chk("ovf_unf",  32'(underflow), 32'd0);
`endif

    // Drain and wrap.
    exp_seq = '{32'hA, 32'hB, 32'hC, 32'hD};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_dout", i), data_out, exp_seq[i]);
      cyc(0, 1, 32'h0);
    end
    chk("drain_empty", 32'(status.empty), 32'd1);
    chk("drain_head",  32'(dut.head),     32'd0);
    chk("drain_count", 32'(fifo_count),   32'd0);
    chk("drain_dout",  data_out,          32'd0);
    chk_mem("drain", 32'hA, 32'hB, 32'hC, 32'hD);

    // Pop while empty: ignored.
    cyc(0, 1, 32'h0);
    chk("unf_count", 32'(fifo_count), 32'd0);
    chk("unf_head",  32'(dut.head),   32'd0);
`ifdef PIO_FIFO_ERR_FLAGS_EN
    chk("unf_flag", 32'(underflow), 32'd1);
`endif

    // Refill, then push+pop while full.
    cyc(1, 0, 32'h1A);
    cyc(1, 0, 32'h1B);
    cyc(1, 0, 32'h1C);
    cyc(1, 0, 32'h1D);
    chk("refill_full", 32'(status.full), 32'd1);
    cyc(1, 1, 32'hF);
    chk("sim_full_count", 32'(fifo_count), 32'd4);
    chk("sim_full_dout",  data_out,        32'h1B);
    chk("sim_full_head",  32'(dut.head),   32'd1);
    chk("sim_full_tail",  32'(dut.tail),   32'd1);
    chk_mem("sim_full", 32'hF, 32'h1B, 32'h1C, 32'h1D);

    exp_seq = '{32'h1B, 32'h1C, 32'h1D, 32'hF};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain2_%0d_dout", i), data_out, exp_seq[i]);
      cyc(0, 1, 32'h0);
    end
    chk("drain2_empty", 32'(status.empty), 32'd1);

    // Push+pop while empty: only the push takes effect (head=tail=1 here).
    cyc(1, 1, 32'h1);
    chk("sim_empty_count", 32'(fifo_count), 32'd1);
    chk("sim_empty_dout",  data_out,        32'h1);
    chk("sim_empty_head",  32'(dut.head),   32'd1);
    chk("sim_empty_tail",  32'(dut.tail),   32'd2);

    // Async reset mid-cycle with two entries held.
    cyc(1, 0, 32'h2);
    chk("pre_rst_count", 32'(fifo_count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(fifo_count),   32'd0);
    chk("arst_empty", 32'(status.empty), 32'd1);
    chk("arst_full",  32'(status.full),  32'd0);
    chk("arst_dout",  data_out,          32'd0);
    chk("arst_head",  32'(dut.head),     32'd0);
    chk("arst_tail",  32'(dut.tail),     32'd0);
    chk_mem("arst", 0, 0, 0, 0);
`ifdef PIO_FIFO_ERR_FLAGS_EN
    chk("arst_ovf", 32'(overflow),  32'd0);
    chk("arst_unf", 32'(underflow), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
